ps2_keyboard: RTL and testbench

PS/2 keyboard receiver that produces the `keyboard_data` / `keyboard_ready` pair consumed by the game logic.
- Samples the keyboard's open-collector clock/data lines and deframes 11-bit PS/2 frames.
- Strips break (F0) sequences, tags extended (E0) codes, and presents each make code as one ready pulse.
- The consumer acts on the falling edge of `keyboard_ready`. This block guarantees the data is stable around that edge.

---
 rtl/ps2_keyboard.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard.sv
`timescale 1ns/1ps
// ps2_keyboard: PS/2 keyboard receiver. Deframes 11-bit PS/2 frames, strips
// break (F0) sequences, tags E0-extended codes and presents each make code as
// one keyboard_ready pulse of READY_CYCLES cycles.
// Optional feature macro: PS2_PARITY_CHECK_EN (odd parity enforced when defined).
// Handshake: keyboard_data/keyboard_ext change only on the cycle keyboard_ready
// rises; the consumer samples them around the falling edge of keyboard_ready,
// and ready stays low >= 2 cycles before the next rise so they remain stable.
module ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int READY_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboard_data,
  output logic       keyboard_ready,
  output logic       keyboard_ext,
  output logic       frame_err,
  output logic [1:0] dbg_state
);

  localparam int             WDW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     READY_LOAD = 8'(READY_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // ---------------- input conditioning ----------------
  logic [2:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       fall;
  logic       din;

  // Two-flop synchronisers, plus a third clock flop for edge detection.
  // Reset to the idle-high line level so reset never fabricates an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign din  = dat_sync_q[1];

  // ---------------- frame FSM ----------------
  state_t         state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           dlv_q, dlv_d;
  logic           err_q, err_d;
  logic           par_ok;

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shreg_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // Frame state register, shift register, watchdog and delivery/error strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      wd_q     <= '0;
      dlv_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      wd_q     <= wd_d;
      dlv_q    <= dlv_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: bits are taken on each synchronised falling edge; the
  // watchdog aborts a frame that stalls mid-way.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    dlv_d    = 1'b0;
    err_d    = 1'b0;
    wd_d     = (state_q == ST_IDLE || fall) ? '0 : wd_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (fall && !din) begin
          bitcnt_d = '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shreg_d = {din, shreg_q[7:1]};
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = din;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (din && par_ok) dlv_d = 1'b1;
          else               err_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && !fall && wd_q == WD_LAST) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  // ---------------- decode stage ----------------
  logic       brk_q, brk_d;
  logic       extp_q, extp_d;
  logic       emit_q, emit_d;
  logic [7:0] emit_code_q, emit_code_d;
  logic       emit_ext_q, emit_ext_d;

  // Pending-prefix flags and the one-cycle emit strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk_q       <= 1'b0;
      extp_q      <= 1'b0;
      emit_q      <= 1'b0;
      emit_code_q <= '0;
      emit_ext_q  <= 1'b0;
    end else begin
      brk_q       <= brk_d;
      extp_q      <= extp_d;
      emit_q      <= emit_d;
      emit_code_q <= emit_code_d;
      emit_ext_q  <= emit_ext_d;
    end
  end

  // Classify each delivered byte. shreg_q still holds the byte here because a
  // new frame cannot shift data within one cycle of the stop bit.
  always_comb begin
    brk_d       = brk_q;
    extp_d      = extp_q;
    emit_d      = 1'b0;
    emit_code_d = emit_code_q;
    emit_ext_d  = emit_ext_q;
    if (dlv_q) begin
      if (shreg_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shreg_q == 8'hE0) begin
        extp_d = 1'b1;
      end else if (brk_q) begin
        brk_d  = 1'b0;
        extp_d = 1'b0;
      end else begin
        emit_d      = 1'b1;
        emit_code_d = shreg_q;
        emit_ext_d  = extp_q;
        extp_d      = 1'b0;
      end
    end
    if (err_q) begin
      brk_d  = 1'b0;
      extp_d = 1'b0;
    end
  end

  // ---------------- output stage ----------------
  logic       rdy_q, rdy_d;
  logic       rdy_prev_q;
  logic [7:0] rcnt_q, rcnt_d;
  logic [7:0] data_q, data_d;
  logic       ext_q, ext_d;
  logic       buf_vld_q, buf_vld_d;
  logic [7:0] buf_data_q, buf_data_d;
  logic       buf_ext_q, buf_ext_d;
  logic       free;

  // Outputs, ready counter and the one-entry holding buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      rdy_prev_q <= 1'b0;
      rcnt_q     <= '0;
      data_q     <= '0;
      ext_q      <= 1'b0;
      buf_vld_q  <= 1'b0;
      buf_data_q <= '0;
      buf_ext_q  <= 1'b0;
    end else begin
      rdy_q      <= rdy_d;
      rdy_prev_q <= rdy_q;
      rcnt_q     <= rcnt_d;
      data_q     <= data_d;
      ext_q      <= ext_d;
      buf_vld_q  <= buf_vld_d;
      buf_data_q <= buf_data_d;
      buf_ext_q  <= buf_ext_d;
    end
  end

  // Free once ready has been low for two full cycles; the buffered code goes
  // out first and a new code arriving at the same time takes its buffer slot.
  assign free = !rdy_q && !rdy_prev_q;

  always_comb begin
    rdy_d      = rdy_q;
    rcnt_d     = rcnt_q;
    data_d     = data_q;
    ext_d      = ext_q;
    buf_vld_d  = buf_vld_q;
    buf_data_d = buf_data_q;
    buf_ext_d  = buf_ext_q;
    if (rdy_q) begin
      if (rcnt_q <= 8'd1) begin
        rdy_d  = 1'b0;
        rcnt_d = '0;
      end else begin
        rcnt_d = rcnt_q - 8'd1;
      end
    end
    if (free && buf_vld_q) begin
      data_d    = buf_data_q;
      ext_d     = buf_ext_q;
      rdy_d     = 1'b1;
      rcnt_d    = READY_LOAD;
      buf_vld_d = emit_q;
      if (emit_q) begin
        buf_data_d = emit_code_q;
        buf_ext_d  = emit_ext_q;
      end
    end else if (free && emit_q) begin
      data_d = emit_code_q;
      ext_d  = emit_ext_q;
      rdy_d  = 1'b1;
      rcnt_d = READY_LOAD;
    end else if (emit_q) begin
      buf_vld_d  = 1'b1;
      buf_data_d = emit_code_q;
      buf_ext_d  = emit_ext_q;
    end
  end

  assign keyboard_data  = data_q;
  assign keyboard_ready = rdy_q;
  assign keyboard_ext   = ext_q;
  assign frame_err      = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
`timescale 1ns/1ps
// tb_ps2_keyboard: directed PS/2 frames into two receivers (READY_CYCLES 4 and
// 60, both with TIMEOUT_CYCLES 50); a negedge monitor records every ready
// pulse, and an expected queue of {ext, code} is compared after each scenario.
module tb_ps2_keyboard;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] kd_a, kd_b;
  logic       rdy_a, rdy_b, ext_a, ext_b, err_a, err_b;
  logic [1:0] dbg_a, dbg_b;

  ps2_keyboard #(.TIMEOUT_CYCLES(50), .READY_CYCLES(4)) u_dut_a (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboard_data(kd_a), .keyboard_ready(rdy_a), .keyboard_ext(ext_a),
    .frame_err(err_a), .dbg_state(dbg_a)
  );

  ps2_keyboard #(.TIMEOUT_CYCLES(50), .READY_CYCLES(60)) u_dut_b (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboard_data(kd_b), .keyboard_ready(rdy_b), .keyboard_ext(ext_b),
    .frame_err(err_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got0_q[$];
  logic [8:0] got1_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_codes(input string tag);
    check({tag, "_count"}, got0_q.size(), exp_q.size());
    while (got0_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_code"}, got0_q.pop_front(), exp_q.pop_front());
    got0_q.delete();
    exp_q.delete();
  endtask

  // ---------------- monitor ----------------
  int   rise_cnt[2]  = '{0, 0};
  int   last_rise[2] = '{0, 0};
  int   last_fall[2] = '{0, 0};
  int   last_gap[2]  = '{0, 0};
  int   min_gap[2]   = '{1000, 1000};
  int   hi_len[2]    = '{0, 0};
  int   len_bad[2]   = '{0, 0};
  int   glitch[2]    = '{0, 0};
  int   err_hi[2]    = '{0, 0};
  int   err_cyc[2]   = '{0, 0};
  int   rlen[2]      = '{4, 60};
  bit   have_fall[2] = '{0, 0};
  logic prev_rdy[2]  = '{1'b0, 1'b0};
  logic prev_ext[2]  = '{1'b0, 1'b0};
  logic prev_err[2]  = '{1'b0, 1'b0};
  logic [7:0] prev_kd[2] = '{8'h00, 8'h00};

  task automatic mon(input int i, input logic r, input logic [7:0] d, input logic e, input logic fe);
    if (!rst) begin
      if (r && !prev_rdy[i]) begin
        rise_cnt[i]++;
        last_rise[i] = cyc;
        hi_len[i] = 0;
        if (have_fall[i]) begin
          last_gap[i] = cyc - last_fall[i];
          if (last_gap[i] < min_gap[i]) min_gap[i] = last_gap[i];
        end
        if (i == 0) got0_q.push_back({e, d});
        else        got1_q.push_back({e, d});
      end else if (d !== prev_kd[i] || e !== prev_ext[i]) begin
        glitch[i]++;
      end
      if (r) hi_len[i]++;
      if (!r && prev_rdy[i]) begin
        last_fall[i] = cyc;
        have_fall[i] = 1'b1;
        if (hi_len[i] != rlen[i]) len_bad[i]++;
      end
      if (fe) begin
        err_hi[i]++;
        if (!prev_err[i]) err_cyc[i] = cyc;
      end
    end
    prev_rdy[i] = r;
    prev_kd[i]  = d;
    prev_ext[i] = e;
    prev_err[i] = fe;
  endtask

  always @(negedge clk) begin
    mon(0, rdy_a, kd_a, ext_a, err_a);
    mon(1, rdy_b, kd_b, ext_b, err_b);
  end

  // ---------------- drivers ----------------
  int last_fall_cyc = 0;

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int half);
    @(negedge clk);
    ps2_data = b;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int half);
    logic par;
    par = ~(^b) ^ flip_par;
    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(b[i], half);
    send_bit(par, half);
    send_bit(1'b1, half);
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  int t_stop, r0, e0, exp_perr;

  initial begin
    settle(5);
    check("rst_ready", rdy_a, 0);
    check("rst_data", kd_a, 0);
    check("rst_ext", ext_a, 0);
    check("rst_err", err_a, 0);
    check("rst_state", {dbg_b, dbg_a}, 0);
    rst = 1'b0;
    settle(5);

    // Plain make code; ready rises 5 cycles after the stop bit is driven low
    // (3 synchroniser/edge cycles + decode + output load).
    exp_q.push_back({1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0, 8);
    t_stop = last_fall_cyc;
    settle(40);
    check("t1_latency", last_rise[0] - t_stop, 5);
    expect_codes("t1");
    check("t1_hold", kd_a, 8'h1C);

    // Break sequence is swallowed, the next make code comes through.
    r0 = rise_cnt[0];
    send_frame(8'hF0, 1'b0, 8);
    settle(20);
    send_frame(8'h1C, 1'b0, 8);
    settle(40);
    check("t2_release", rise_cnt[0] - r0, 0);
    exp_q.push_back({1'b0, 8'h23});
    send_frame(8'h23, 1'b0, 8);
    settle(40);
    expect_codes("t2");

    // Extended code tagged, flag cleared for the following code.
    exp_q.push_back({1'b1, 8'h6B});
    exp_q.push_back({1'b0, 8'h29});
    send_frame(8'hE0, 1'b0, 8);
    settle(20);
    send_frame(8'h6B, 1'b0, 8);
    settle(40);
    send_frame(8'h29, 1'b0, 8);
    settle(40);
    expect_codes("t3");

    // Flipped parity bit.
`ifdef PS2_PARITY_CHECK_EN
    exp_perr = 1;
`else
    exp_perr = 0;
    exp_q.push_back({1'b0, 8'h1D});
`endif
    e0 = err_hi[0];
    send_frame(8'h1D, 1'b1, 8);
    settle(40);
    check("t4_err", err_hi[0] - e0, exp_perr);
    expect_codes("t4");

    // Frame stalls after 4 data bits: error 50 cycles after the synchronised
    // last fall, i.e. 53 cycles after it was driven.
    e0 = err_hi[0];
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    send_bit(1'b1, 8);
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    t_stop = last_fall_cyc;
    for (int k = 0; k < 200 && err_hi[0] == e0; k++) @(negedge clk);
    settle(5);
    check("t5_err_width", err_hi[0] - e0, 1);
    check("t5_err_time", err_cyc[0] - t_stop, 53);
    exp_q.push_back({1'b0, 8'h1B});
    send_frame(8'h1B, 1'b0, 8);
    settle(40);
    expect_codes("t5_after");

    // Back-to-back fast frames: the long-ready receiver buffers 0x23 and
    // presents it exactly 2 low cycles after the first pulse.
    got1_q.delete();
    exp_q.push_back({1'b0, 8'h1C});
    exp_q.push_back({1'b0, 8'h23});
    send_frame(8'h1C, 1'b0, 2);
    send_frame(8'h23, 1'b0, 2);
    settle(200);
    expect_codes("t6_a");
    check("t6_b_count", got1_q.size(), 2);
    if (got1_q.size() > 0) check("t6_b_first", got1_q.pop_front(), {1'b0, 8'h1C});
    if (got1_q.size() > 0) check("t6_b_second", got1_q.pop_front(), {1'b0, 8'h23});
    check("t6_b_gap", last_gap[1], 2);

    // Reset mid-frame: outputs clear, no error afterwards.
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    send_bit(1'b0, 8);
    @(negedge clk);
    ps2_data = 1'b1;
    rst = 1'b1;
    r0 = rise_cnt[0];
    e0 = err_hi[0];
    settle(3);
    check("t7_rst_data", kd_a, 0);
    check("t7_rst_ready", {rdy_b, rdy_a}, 0);
    check("t7_rst_err", {err_b, err_a, ext_a}, 0);
    rst = 1'b0;
    settle(120);
    check("t7_no_err", err_hi[0] - e0, 0);
    check("t7_no_ready", rise_cnt[0] - r0, 0);
    exp_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b0, 8);
    settle(40);
    expect_codes("t7_after");

    // Whole-run output properties.
    check("glitch_a", glitch[0], 0);
    check("glitch_b", glitch[1], 0);
    check("len_a", len_bad[0], 0);
    check("len_b", len_bad[1], 0);
    check("min_gap_a", (min_gap[0] >= 2), 1);
    check("min_gap_b", (min_gap[1] >= 2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
